// File: rtl/label_map_reader.sv
// Scans the 32x32 label map in label SRAM and re-packs it into a 128-byte foreground bitmap with pixel count and max label.
// Latency: first byte 9 cycles after start acceptance, then 9 FETCH + 1 EMIT cycles per byte; done 1280 cycles after FETCH entry when never stalled.
// Backpressure: a byte is held stable in EMIT until out_valid && out_ready; fetching of the next byte waits for that handshake.
module label_map_reader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [9:0]  sram_a,
    output logic        sram_wen,
    input  logic [7:0]  sram_q,
    output logic [7:0]  out_data,
    output logic [6:0]  out_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] fg_count,
    output logic [7:0]  label_max,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    state_t      state;
    logic [6:0]  b;      // byte index being assembled
    logic [3:0]  k;      // cycle within the 9-cycle fetch of one byte
    logic [6:0]  pack;   // low 7 bits of the byte; bit 7 comes straight from the last sample
    logic        nz;

    // The engine only ever reads label SRAM.
    assign sram_wen = 1'b1;

    // Foreground test for the label arriving this cycle.
    assign nz = (sram_q != 8'd0);

    // Scan FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            b         <= 7'd0;
            k         <= 4'd0;
            pack      <= 7'd0;
            sram_a    <= 10'd0;
            out_data  <= 8'd0;
            out_addr  <= 7'd0;
            out_valid <= 1'b0;
            fg_count  <= 11'd0;
            label_max <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        fg_count  <= 11'd0;
                        label_max <= 8'd0;
                        b         <= 7'd0;
                        k         <= 4'd0;
                        sram_a    <= 10'd0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    // Address for the next cycle; holds at 8*b+7 once the last read is issued.
                    if (k < 4'd7)
                        sram_a <= {b, k[2:0] + 3'd1};
                    // sram_q now carries the label of address 8*b+k-1.
                    if (k != 4'd0) begin
                        fg_count <= fg_count + {10'd0, nz};
                        if (sram_q > label_max)
                            label_max <= sram_q;
                    end
                    if (k != 4'd0 && k != 4'd8)
                        pack[k[2:0] - 3'd1] <= nz;
                    if (k == 4'd8) begin
                        out_data  <= {nz, pack};
                        out_addr  <= b;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (b == 7'd127) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            b      <= b + 7'd1;
                            k      <= 4'd0;
                            sram_a <= {b + 7'd1, 3'd0};
                            state  <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_label_map_reader.sv
// Randomized bench for label_map_reader: SRAM model, bitmap/count reference, per-cycle stream monitor.
// Latency: checks first-byte and done timing against the stated cycle counts.
// Backpressure: drives out_ready tied high, toggling, random, and verifies stall stability.
module tb_label_map_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  sram_a;
    logic        sram_wen;
    logic [7:0]  sram_q = 8'd0;
    logic [7:0]  out_data;
    logic [6:0]  out_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] fg_count;
    logic [7:0]  label_max;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mode = 0;        // 0 ready high, 1 toggle, 2 random, 3 low
    int done_cnt = 0;

    logic [7:0] mem [1024];
    logic [7:0] exp_bytes [128];
    logic [7:0] obs_bytes [128];
    int exp_fg;
    int exp_lm;

    label_map_reader dut (
        .clk(clk), .reset(reset), .start(start),
        .sram_a(sram_a), .sram_wen(sram_wen), .sram_q(sram_q),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
        .fg_count(fg_count), .label_max(label_max), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM: data follows the address of the previous cycle.
    always @(posedge clk) sram_q <= mem[sram_a];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: bitmap byte j bit i is set when label 8j+i is nonzero.
    task automatic build_model();
        exp_fg = 0;
        exp_lm = 0;
        for (int j = 0; j < 128; j++) begin
            exp_bytes[j] = 8'd0;
            for (int i = 0; i < 8; i++)
                if (mem[8*j+i] != 8'd0) exp_bytes[j][i] = 1'b1;
        end
        for (int a = 0; a < 1024; a++) begin
            if (mem[a] != 8'd0) exp_fg++;
            if (int'(mem[a]) > exp_lm) exp_lm = int'(mem[a]);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_sram_a", int'(sram_a), 0);
        check("rst_sram_wen", int'(sram_wen), 1);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_addr", int'(out_addr), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fg_count", int'(fg_count), 0);
        check("rst_label_max", int'(label_max), 0);
    endtask

    // out_ready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle monitor, sampling on the falling edge.
    int   hs_idx = 0;
    int   start_cyc = 0;
    bit   prev_busy = 0, prev_done = 0, prev_stall = 0, fv_pend = 0;
    logic [7:0] stall_data;
    logic [6:0] stall_addr;

    always @(negedge clk) begin
        if (reset) begin
            hs_idx = 0; prev_busy = 0; prev_done = 0; prev_stall = 0; fv_pend = 0;
        end else begin
            check("sram_wen_high", int'(sram_wen), 1);
            if (busy && !prev_busy) begin
                start_cyc = cyc;
                fv_pend = 1;
                hs_idx = 0;
            end
            if (fv_pend && out_valid) begin
                check("first_valid_latency", cyc - start_cyc, 9);
                fv_pend = 0;
            end
            if (prev_stall) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), int'(stall_data));
                check("stall_addr", int'(out_addr), int'(stall_addr));
            end
            if (out_valid && out_ready) begin
                if (hs_idx < 128) begin
                    check("out_addr_order", int'(out_addr), hs_idx);
                    check("out_data", int'(out_data), int'(exp_bytes[hs_idx]));
                    obs_bytes[out_addr] = out_data;
                end else begin
                    check("extra_byte", hs_idx, 127);
                end
                hs_idx++;
            end
            prev_stall = out_valid && !out_ready;
            stall_data = out_data;
            stall_addr = out_addr;
            if (prev_done) check("done_one_cycle", int'(done), 0);
            if (done) begin
                done_cnt++;
                check("done_busy_low", int'(busy), 0);
                check("bytes_per_scan", hs_idx, 128);
                check("fg_count", int'(fg_count), exp_fg);
                check("label_max", int'(label_max), exp_lm);
                if (mode == 0) check("done_latency", cyc - start_cyc, 1280);
            end
            prev_done = done;
            prev_busy = busy;
        end
    end

    task automatic run_scan(input int rmode, input bit pulse_mid);
        int d0;
        int n;
        build_model();
        mode = rmode;
        d0 = done_cnt;
        n = 0;
        while (busy && n < 5000) begin @(negedge clk); n++; end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (pulse_mid) begin
            repeat (300) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 6000) begin @(negedge clk); n++; end
        check("scan_timeout", int'(n < 6000), 1);
        repeat (5) @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("idle_after_done", int'(busy), 0);
        mode = 0;
    endtask

    initial begin
        int n;
        for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals();

        // All-zero map, ready high.
        run_scan(0, 0);
        check("zero_fg_lit", int'(fg_count), 0);
        check("zero_lm_lit", int'(label_max), 0);

        // All labels = 1.
        for (int a = 0; a < 1024; a++) mem[a] = 8'd1;
        run_scan(0, 0);
        check("ones_fg_lit", int'(fg_count), 1024);
        check("ones_lm_lit", int'(label_max), 1);
        check("ones_byte77_lit", int'(obs_bytes[77]), 8'hFF);

        // Single label 3 at address 9.
        for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
        mem[9] = 8'd3;
        run_scan(0, 0);
        check("single_model_lit", int'(exp_bytes[1]), 8'h02);
        check("single_byte1_lit", int'(obs_bytes[1]), 8'h02);
        check("single_byte0_lit", int'(obs_bytes[0]), 8'h00);
        check("single_fg_lit", int'(fg_count), 1);
        check("single_lm_lit", int'(label_max), 3);

        // Checkerboard, labels 1..200 on even addresses, toggling ready.
        for (int a = 0; a < 1024; a++)
            mem[a] = (a % 2 == 0) ? 8'(((a / 2) % 200) + 1) : 8'd0;
        run_scan(1, 0);
        check("chk_fg_lit", int'(fg_count), 512);
        check("chk_lm_lit", int'(label_max), 200);
        check("chk_byte5_lit", int'(obs_bytes[5]), 8'h55);

        // Random labels, random ready, start pulsed mid-scan.
        for (int a = 0; a < 1024; a++)
            mem[a] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        run_scan(2, 1);

        // Reset while byte 40 is presented in EMIT.
        mode = 2;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_addr == 7'd40) && n < 5000) begin @(negedge clk); n++; end
        check("reach_byte40", int'(n < 5000), 1);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        mode = 0;
        repeat (4) @(negedge clk);
        check("no_restart_after_reset", int'(busy), 0);
        check("no_done_after_reset", done_cnt, 5);

        // Fresh scan after reset, random map and ready.
        for (int a = 0; a < 1024; a++)
            mem[a] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        run_scan(2, 0);
        check("total_done_pulses", done_cnt, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/label_map_reader.md
# label_map_reader

Readback engine for the labeled image that the connected-component labeling engine leaves in label SRAM. It scans the 1024-entry label map (32x32 pixels, one 8-bit label per pixel, address = row*32+col) and re-packs it into a 128-byte foreground bitmap. The bitmap uses the same byte/bit layout as the binary image ROM, so the bench or downstream logic can compare it against the source image. It also reports foreground pixel count and the highest label used, and streams the bitmap out over a valid/ready port.

## Interface
- No parameters; geometry is fixed at 32x32 pixels, 1024 labels, 128 output bytes.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- sram_a  out  10  label SRAM address; registered output.
- sram_wen  out  1  SRAM write enable, active-low; held at 1 (read-only) at all times.
- sram_q  in  8  label SRAM read data; value in cycle t belongs to the sram_a presented in cycle t-1.
- out_data  out  8  packed bitmap byte; bit i = (label at address 8*out_addr+i != 0).
- out_addr  out  7  index of out_data (0..127).
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge.
- fg_count  out  11  number of nonzero labels (0..1024); valid when done=1.
- label_max  out  8  maximum label value read; valid when done=1.
- busy  out  1  high from the start acceptance edge until DONE is entered.
- done  out  1  one-cycle pulse at scan completion.

## Operation
- Reset values: sram_a=0, sram_wen=1, out_data=0, out_addr=0, out_valid=0, busy=0, done=0, fg_count=0, label_max=0, state=IDLE.
- FSM states: IDLE, FETCH, EMIT, DONE.
- IDLE: if start=1, clear fg_count, label_max, byte index b and sub-counter k; set busy=1; go to FETCH. start is ignored in every other state.
- FETCH lasts 9 cycles per byte, k=0..8.
  - For k=0..7, sram_a=8*b+k.
  - For k=1..8, sample sram_q (the label of address 8*b+k-1) into shift/pack bit k-1.
  - On each sample, fg_count increments if the label is nonzero, and label_max becomes max(label_max, sram_q).
  - After the k=8 sample, load out_data, set out_addr=b, out_valid=1, and go to EMIT.
- EMIT: out_data, out_addr and out_valid stay stable until a handshake occurs.
  - On handshake, out_valid drops to 0.
  - If b=127, go to DONE; otherwise increment b, clear k, and go to FETCH.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. fg_count and label_max hold until the next accepted start.
- sram_a holds its last value outside FETCH cycles k=0..7.
- Arithmetic:
  - fg_count is 11 bits and reaches 1024 without overflow.
  - b is 7 bits and never wraps inside a scan; termination is by the b=127 check.
  - label_max is an unsigned compare.
- Reset asserted mid-scan returns everything to reset values immediately; no partial done pulse. A new start is required afterwards.
- A start in the same cycle as the DONE state is ignored; start is accepted only from IDLE.

## Timing
- Start accepted at edge E0: the first FETCH cycle follows E0, and sram_a=0 in that cycle.
- First out_valid rises 9 cycles after FETCH entry.
- With out_ready tied high, each byte costs 10 cycles (9 FETCH + 1 EMIT). DONE is entered 1280 cycles after FETCH entry.
- Each cycle of out_ready=0 in EMIT adds one cycle; no data is lost or reordered.
- No combinational path from out_ready or sram_q to any output.

## Test plan
- All-zero label map, out_ready=1 -> 128 bytes of 0x00 with out_addr 0..127 in order; fg_count=0, label_max=0; done exactly 1280 cycles after FETCH entry.
- All labels=1 -> every byte 0xFF; fg_count=1024, label_max=1.
- Single label 3 at address 9 (row 0, col 9), rest 0 -> byte 1 = 0x02, all others 0x00; fg_count=1, label_max=3.
- Checkerboard (labels 1..200 on even addresses) with out_ready toggling 0/1 each cycle -> every byte 0x55, out_data stable while out_valid&&!out_ready; fg_count=512, label_max=200.
- start pulsed again during a scan -> ignored: single done pulse, out_addr sequence unbroken; sram_wen=1 throughout.
- reset asserted at byte 40 during EMIT -> next cycle all outputs at reset values; a new start produces a complete scan beginning at out_addr 0.
